daten_bus_bruecke: RTL and testbench
====================================

# daten_bus_bruecke

Parametrised data-bus bridge between the CPU data port and the data RAM plus a bank of memory-mapped I/O registers. It replaces the single hard-wired LED register and combinational address split with a registered transaction state machine. The state machine adds a request/acknowledge protocol, `IO_REGS` output registers with read-back, a RAM timeout and a sticky error status. It sits in the top module between `CPU` and the `DatenRAM` `RAM` instance; the I/O outputs drive board pins such as `led`.

## Interface
- `WORDSIZE`, 32, data word width
- `IO_REGS`, 4, number of I/O output registers (1..255)
- `IO_WIDTH`, 8, width of each I/O register (≤ `WORDSIZE`)
- `TIMEOUT`, 15, maximum cycles spent waiting for a RAM acknowledge (≥ 1)

- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: reset is asynchronous and active-low.
- `LeseDaten` in 1: CPU read request, level, held until acknowledged.
- `SchreibeDaten` in 1: CPU write request, level, held until acknowledged.
- `DatenAdresse` in 32: CPU address. Bit 31 = 0 selects RAM; bit 31 = 1 selects I/O, with index `DatenAdresse[7:0]`.
- `DatenRaus` in `WORDSIZE`: CPU write data.
- `DatenRein` out `WORDSIZE`: read data to the CPU.
- `DatenGeladen` out 1: read acknowledge, one-cycle pulse.
- `DatenGespeichert` out 1: write acknowledge, one-cycle pulse.
- `BusFehler` out 1: error flag, valid only during an acknowledge pulse.
- `RAMLeseDaten`, `RAMSchreibeDaten` out 1: registered RAM strobes.
- `RAMAdresse` out 32: latched address.
- `RAMDatenSchreiben` out `WORDSIZE`: latched write data.
- `RAMDatenLesen` in `WORDSIZE`: RAM read data.
- `RAMDatenGeladen`, `RAMDatenGespeichert` in 1: RAM completion.
- `IOAusgang` out `IO_REGS*IO_WIDTH`: register k occupies bits `[k*IO_WIDTH +: IO_WIDTH]`.

## Operation
- **States:** `IDLE` → (`RAM_WARTEN` | `ANTWORT`) → `ENDE` → `IDLE`.
- **`IDLE`, on a request:**
  - Latch the address, the write data and the direction.
  - Both `LeseDaten` and `SchreibeDaten` high: no access is made; go to `ANTWORT` with error set and a read-type acknowledge.
- **RAM access:** enter `RAM_WARTEN` and assert the matching strobe from the next cycle.
  - Clear the timeout counter on entry.
  - On a matching RAM completion: drop the strobe, capture `RAMDatenLesen` on reads, go to `ANTWORT`.
  - When the counter reaches `TIMEOUT` with no completion: drop the strobe, set the error, force the read data to 0, go to `ANTWORT`.
- **I/O access, valid index `k < IO_REGS`:**
  - Write: register k ← `DatenRaus[IO_WIDTH-1:0]`.
  - Read: zero-extended register k.
- **I/O index `IO_REGS`:** status register.
  - Read returns `{WORDSIZE-1 zeros, FehlerSticky}`.
  - Write of any value clears `FehlerSticky`.
- **I/O index > `IO_REGS`:** error. Writes are ignored; reads return 0.
- **`ANTWORT`:**
  - Pulse exactly one of `DatenGeladen` or `DatenGespeichert` for one cycle.
  - `BusFehler` mirrors the transaction error.
  - `FehlerSticky` is set on any error.
- **`ENDE`:** wait until `LeseDaten` and `SchreibeDaten` are both 0, then return to `IDLE`. A held request therefore never executes twice.
- **`DatenRein`:** updated only on read completion; holds its value otherwise.
- **Reset (asynchronous, mid-operation):**
  - State returns to `IDLE`, aborting any transaction.
  - RAM strobes, acknowledges, `BusFehler`, `DatenRein`, `FehlerSticky`, all I/O registers, `RAMAdresse` and `RAMDatenSchreiben` go to 0 immediately.
  - No acknowledge is issued for the aborted transaction.

## Timing
- Requests are sampled at the rising edge only while in `IDLE`.
- **I/O latency:** request sampled at edge N → register updated and acknowledge high in cycle N+1.
- **RAM latency:**
  - Strobe high from N+1.
  - RAM completion sampled at edge M → acknowledge in cycle M+1.
- **Timeout:**
  - Strobe held for exactly `TIMEOUT` cycles.
  - Acknowledge with `BusFehler` in cycle N+`TIMEOUT`+1.
- A RAM completion arriving in the same cycle the counter reaches `TIMEOUT` counts as success.
- An I/O write and a status clear in the same transaction are impossible (a single index per transaction). An error in the same cycle as a status-clear write leaves `FehlerSticky` = 1, because the set wins.
- Minimum spacing between two transactions: 3 cycles (`IDLE` → `ANTWORT` → `ENDE` → `IDLE`).

## Test plan
- **Reset:** hold `Reset` = 0 → all outputs 0. Assert `Reset` = 0 asynchronously mid-`RAM_WARTEN` → `RAMLeseDaten` drops without waiting for a clock edge, and no acknowledge follows.
- **I/O write/read:** write `0x000000A5` to `0x80000000`, then read `0x80000000` → `IOAusgang[7:0]` = `0xA5`, and the read returns `0x000000A5` with `DatenGeladen` one cycle after sampling.
- **RAM path:** write `0x12345678` to `0x00000010`, then read it, with the RAM model acknowledging after 2 cycles → acknowledge in cycle N+3, `DatenRein` = `0x12345678`, `BusFehler` = 0.
- **Timeout:** read `0x00000004` with a RAM that never acknowledges → strobe high for 15 cycles, then `DatenGeladen` = 1, `BusFehler` = 1, `DatenRein` = 0. A subsequent read of `0x80000004` returns 1; writing `0x80000004` clears it to 0.
- **Hold/double request:**
  - Keep `SchreibeDaten` high for 10 cycles → exactly one write and one `DatenGespeichert` pulse.
  - Raise both `LeseDaten` and `SchreibeDaten` → error acknowledge, and no RAM strobe.
- **Invalid index:** write `0x80000009` → `BusFehler` = 1, and `IOAusgang` is unchanged.

Source files
------------

// File: rtl/daten_bus_bruecke.sv
// daten_bus_bruecke: bridge between the CPU data port, the data RAM and a bank of
// memory-mapped I/O registers.
//
// Each transaction runs IDLE -> (RAM_WARTEN | ANTWORT) -> ENDE -> IDLE.
// Address bit 31 = 0 selects the RAM and bit 31 = 1 selects I/O, indexed by address[7:0].
// Index < IO_REGS is an output register. Index == IO_REGS is the status register
// (sticky error bit; any write clears it). Any larger index is a bus error.
//
// Ports:
//   Clock, Reset                    clock (rising edge), asynchronous active-low reset
//   LeseDaten, SchreibeDaten        CPU read/write request levels, held until acknowledged
//   DatenAdresse, DatenRaus         CPU address and write data
//   DatenRein                       read data to the CPU, changes only on read completion
//   DatenGeladen, DatenGespeichert  one-cycle read/write acknowledge
//   BusFehler                       transaction error, valid during an acknowledge
//   RAMLeseDaten, RAMSchreibeDaten  registered RAM strobes
//   RAMAdresse, RAMDatenSchreiben   latched address and write data
//   RAMDatenLesen                   RAM read data
//   RAMDatenGeladen/-Gespeichert    RAM completion
//   IOAusgang                       I/O registers, register k at [k*IO_WIDTH +: IO_WIDTH]
module daten_bus_bruecke #(
  parameter int unsigned WORDSIZE = 32,
  parameter int unsigned IO_REGS  = 4,
  parameter int unsigned IO_WIDTH = 8,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         LeseDaten,
  input  logic                         SchreibeDaten,
  input  logic [31:0]                  DatenAdresse,
  input  logic [WORDSIZE-1:0]          DatenRaus,
  output logic [WORDSIZE-1:0]          DatenRein,
  output logic                         DatenGeladen,
  output logic                         DatenGespeichert,
  output logic                         BusFehler,
  output logic                         RAMLeseDaten,
  output logic                         RAMSchreibeDaten,
  output logic [31:0]                  RAMAdresse,
  output logic [WORDSIZE-1:0]          RAMDatenSchreiben,
  input  logic [WORDSIZE-1:0]          RAMDatenLesen,
  input  logic                         RAMDatenGeladen,
  input  logic                         RAMDatenGespeichert,
  output logic [IO_REGS*IO_WIDTH-1:0]  IOAusgang
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  // Counter value during the last strobe cycle before a timeout.
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRamWarten, StAntwort, StEnde} state_e;

  state_e                      state_q, state_d;
  logic [31:0]                 adr_q, adr_d;
  logic [WORDSIZE-1:0]         wdata_q, wdata_d;
  logic [WORDSIZE-1:0]         rdata_q, rdata_d;
  logic                        is_write_q, is_write_d;
  logic                        err_q, err_d;
  logic                        sticky_q, sticky_d;
  logic                        ram_rd_q, ram_rd_d;
  logic                        ram_wr_q, ram_wr_d;
  logic [CntW-1:0]             cnt_q, cnt_d;
  logic [IO_REGS*IO_WIDTH-1:0] io_q, io_d;

  logic                        req, req_both, is_io;
  logic [7:0]                  idx;
  logic                        idx_valid, idx_status;
  logic                        ram_done, cnt_last;
  logic [WORDSIZE-1:0]         io_rd_val;

  always_comb begin
    req        = LeseDaten | SchreibeDaten;
    req_both   = LeseDaten & SchreibeDaten;
    is_io      = DatenAdresse[31];
    idx        = DatenAdresse[7:0];
    idx_valid  = 32'(idx) < IO_REGS;
    idx_status = 32'(idx) == IO_REGS;
    ram_done   = (ram_rd_q & RAMDatenGeladen) | (ram_wr_q & RAMDatenGespeichert);
    cnt_last   = cnt_q == TimeoutLast;
  end

  // Read value of the addressed I/O location; invalid indices read as zero.
  always_comb begin
    io_rd_val = '0;
    if (idx_status) begin
      io_rd_val[0] = sticky_q;
    end else begin
      for (int unsigned k = 0; k < IO_REGS; k++) begin
        if (32'(idx) == k) io_rd_val[IO_WIDTH-1:0] = io_q[k*IO_WIDTH +: IO_WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (req_both || is_io) state_d = StAntwort;
          else                   state_d = StRamWarten;
        end
      end
      StRamWarten: if (ram_done || cnt_last) state_d = StAntwort;
      StAntwort:   state_d = StEnde;
      StEnde:      if (!req) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    DatenGeladen      = (state_q == StAntwort) && !is_write_q;
    DatenGespeichert  = (state_q == StAntwort) && is_write_q;
    BusFehler         = (state_q == StAntwort) && err_q;
    DatenRein         = rdata_q;
    RAMLeseDaten      = ram_rd_q;
    RAMSchreibeDaten  = ram_wr_q;
    RAMAdresse        = adr_q;
    RAMDatenSchreiben = wdata_q;
    IOAusgang         = io_q;
  end

  // Datapath next-state
  always_comb begin
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_write_d = is_write_q;
    err_d      = err_q;
    sticky_d   = sticky_q;
    ram_rd_d   = ram_rd_q;
    ram_wr_d   = ram_wr_q;
    cnt_d      = cnt_q;
    io_d       = io_q;

    if (state_q == StIdle && req) begin
      adr_d      = DatenAdresse;
      wdata_d    = DatenRaus;
      // A double request is answered with a read-type acknowledge.
      is_write_d = SchreibeDaten & ~LeseDaten;
      err_d      = 1'b0;
      if (req_both) begin
        err_d = 1'b1;
      end else if (is_io) begin
        if (!idx_valid && !idx_status) err_d = 1'b1;
        if (SchreibeDaten) begin
          if (idx_status) sticky_d = 1'b0;
          for (int unsigned k = 0; k < IO_REGS; k++) begin
            if (32'(idx) == k) io_d[k*IO_WIDTH +: IO_WIDTH] = DatenRaus[IO_WIDTH-1:0];
          end
        end else begin
          rdata_d = io_rd_val;
        end
      end else begin
        ram_rd_d = LeseDaten;
        ram_wr_d = SchreibeDaten;
        cnt_d    = '0;
      end
    end

    if (state_q == StRamWarten) begin
      // Completion wins over a timeout in the same cycle.
      if (ram_done) begin
        ram_rd_d = 1'b0;
        ram_wr_d = 1'b0;
        if (ram_rd_q) rdata_d = RAMDatenLesen;
      end else if (cnt_last) begin
        ram_rd_d = 1'b0;
        ram_wr_d = 1'b0;
        err_d    = 1'b1;
        if (ram_rd_q) rdata_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Setting the sticky bit has priority over a clear.
    if (state_q == StAntwort && err_q) sticky_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      adr_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_write_q <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      cnt_q      <= '0;
      io_q       <= '0;
    end else begin
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_write_q <= is_write_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      ram_rd_q   <= ram_rd_d;
      ram_wr_q   <= ram_wr_d;
      cnt_q      <= cnt_d;
      io_q       <= io_d;
    end
  end

endmodule

// File: tb/tb_daten_bus_bruecke.sv
module tb_daten_bus_bruecke;

  logic        Clock;
  logic        Reset;
  logic        LeseDaten;
  logic        SchreibeDaten;
  logic [31:0] DatenAdresse;
  logic [31:0] DatenRaus;
  logic [31:0] DatenRein;
  logic        DatenGeladen;
  logic        DatenGespeichert;
  logic        BusFehler;
  logic        RAMLeseDaten;
  logic        RAMSchreibeDaten;
  logic [31:0] RAMAdresse;
  logic [31:0] RAMDatenSchreiben;
  logic [31:0] RAMDatenLesen;
  logic        RAMDatenGeladen;
  logic        RAMDatenGespeichert;
  logic [31:0] IOAusgang;

  daten_bus_bruecke #(
    .WORDSIZE(32),
    .IO_REGS (4),
    .IO_WIDTH(8),
    .TIMEOUT (15)
  ) dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .LeseDaten          (LeseDaten),
    .SchreibeDaten      (SchreibeDaten),
    .DatenAdresse       (DatenAdresse),
    .DatenRaus          (DatenRaus),
    .DatenRein          (DatenRein),
    .DatenGeladen       (DatenGeladen),
    .DatenGespeichert   (DatenGespeichert),
    .BusFehler          (BusFehler),
    .RAMLeseDaten       (RAMLeseDaten),
    .RAMSchreibeDaten   (RAMSchreibeDaten),
    .RAMAdresse         (RAMAdresse),
    .RAMDatenSchreiben  (RAMDatenSchreiben),
    .RAMDatenLesen      (RAMDatenLesen),
    .RAMDatenGeladen    (RAMDatenGeladen),
    .RAMDatenGespeichert(RAMDatenGespeichert),
    .IOAusgang          (IOAusgang)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // RAM model: completes in the second cycle of a strobe when enabled.
  logic [31:0] mem [16];
  int          ram_cnt = 0;
  bit          ram_en  = 1'b0;
  logic        ram_ack;

  always @(posedge Clock) begin
    if (RAMLeseDaten || RAMSchreibeDaten) ram_cnt <= ram_cnt + 1;
    else                                  ram_cnt <= 0;
    if (RAMDatenGespeichert) mem[RAMAdresse[5:2]] <= RAMDatenSchreiben;
  end

  assign ram_ack             = ram_en && (ram_cnt == 1);
  assign RAMDatenGeladen     = ram_ack & RAMLeseDaten;
  assign RAMDatenGespeichert = ram_ack & RAMSchreibeDaten;
  assign RAMDatenLesen       = mem[RAMAdresse[5:2]];

  int n_vec  = 0;
  int n_err  = 0;
  int last_strb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue a request at a negedge in IDLE, wait (bounded) for the acknowledge and check it.
  task automatic txn(input string tag, input logic rd, input logic wr, input logic [31:0] adr,
                     input logic [31:0] wd, input int exp_lat, input logic exp_err,
                     input logic chk_data, input logic [31:0] exp_data);
    int   lat;
    int   strb;
    logic acked;
    LeseDaten     = rd;
    SchreibeDaten = wr;
    DatenAdresse  = adr;
    DatenRaus     = wd;
    lat   = 0;
    strb  = 0;
    acked = 1'b0;
    while (!acked && lat < 40) begin
      @(negedge Clock);
      lat++;
      if (RAMLeseDaten || RAMSchreibeDaten) strb++;
      if (DatenGeladen || DatenGespeichert) acked = 1'b1;
    end
    last_strb = strb;
    check({tag, "_ack"}, 64'(acked), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_kind"}, 64'({DatenGeladen, DatenGespeichert}), rd ? 64'd2 : 64'd1);
    check({tag, "_err"}, 64'(BusFehler), 64'(exp_err));
    if (chk_data) check({tag, "_data"}, 64'(DatenRein), 64'(exp_data));
    LeseDaten     = 1'b0;
    SchreibeDaten = 1'b0;
    @(negedge Clock);
    check({tag, "_pulse"}, 64'({DatenGeladen, DatenGespeichert}), 64'd0);
    @(negedge Clock);
  endtask

  initial begin
    int pulses;
    Reset         = 1'b0;
    LeseDaten     = 1'b0;
    SchreibeDaten = 1'b0;
    DatenAdresse  = '0;
    DatenRaus     = '0;
    repeat (3) @(negedge Clock);
    check("rst_rein", 64'(DatenRein), 64'd0);
    check("rst_ack", 64'({DatenGeladen, DatenGespeichert, BusFehler}), 64'd0);
    check("rst_strobe", 64'({RAMLeseDaten, RAMSchreibeDaten}), 64'd0);
    check("rst_ramadr", 64'(RAMAdresse), 64'd0);
    check("rst_ramdat", 64'(RAMDatenSchreiben), 64'd0);
    check("rst_io", 64'(IOAusgang), 64'd0);
    Reset = 1'b1;
    @(negedge Clock);

    txn("io_wr", 1'b0, 1'b1, 32'h8000_0000, 32'h0000_00A5, 1, 1'b0, 1'b0, 32'h0);
    check("io_wr_out", 64'(IOAusgang), 64'h0000_00A5);
    txn("io_rd", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1, 1'b0, 1'b1, 32'h0000_00A5);

    ram_en = 1'b1;
    txn("ram_wr", 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 3, 1'b0, 1'b0, 32'h0);
    check("ram_wr_strb", 64'(last_strb), 64'd2);
    txn("ram_rd", 1'b1, 1'b0, 32'h0000_0010, 32'h0, 3, 1'b0, 1'b1, 32'h1234_5678);

    ram_en = 1'b0;
    txn("tmo", 1'b1, 1'b0, 32'h0000_0004, 32'h0, 16, 1'b1, 1'b1, 32'h0);
    check("tmo_strb", 64'(last_strb), 64'd15);
    txn("st_rd", 1'b1, 1'b0, 32'h8000_0004, 32'h0, 1, 1'b0, 1'b1, 32'h1);
    txn("st_clr", 1'b0, 1'b1, 32'h8000_0004, 32'h0, 1, 1'b0, 1'b0, 32'h0);
    txn("st_rd2", 1'b1, 1'b0, 32'h8000_0004, 32'h0, 1, 1'b0, 1'b1, 32'h0);

    // Held write request: must execute and acknowledge exactly once.
    SchreibeDaten = 1'b1;
    DatenAdresse  = 32'h8000_0001;
    DatenRaus     = 32'h0000_003C;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (DatenGespeichert) pulses++;
    end
    SchreibeDaten = 1'b0;
    repeat (2) @(negedge Clock);
    check("hold_pulses", 64'(pulses), 64'd1);
    check("hold_io", 64'(IOAusgang), 64'h0000_3CA5);

    ram_en = 1'b1;
    txn("both", 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 1'b1, 1'b0, 32'h0);
    check("both_strb", 64'(last_strb), 64'd0);
    ram_en = 1'b0;

    txn("inv_wr", 1'b0, 1'b1, 32'h8000_0009, 32'h0000_00FF, 1, 1'b1, 1'b0, 32'h0);
    check("inv_wr_io", 64'(IOAusgang), 64'h0000_3CA5);
    txn("io_rd1", 1'b1, 1'b0, 32'h8000_0001, 32'h0, 1, 1'b0, 1'b1, 32'h0000_003C);
    txn("inv_rd", 1'b1, 1'b0, 32'h8000_0005, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    txn("st_rd3", 1'b1, 1'b0, 32'h8000_0004, 32'h0, 1, 1'b0, 1'b1, 32'h1);
    txn("io_rd0", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1, 1'b0, 1'b1, 32'h0000_00A5);

    // Asynchronous reset while waiting on the RAM.
    LeseDaten    = 1'b1;
    DatenAdresse = 32'h0000_0020;
    repeat (3) @(negedge Clock);
    check("abort_pre", 64'(RAMLeseDaten), 64'd1);
    #2 Reset = 1'b0;
    #1;
    check("abort_strobe", 64'(RAMLeseDaten), 64'd0);
    check("abort_rein", 64'(DatenRein), 64'd0);
    check("abort_io", 64'(IOAusgang), 64'd0);
    check("abort_adr", 64'(RAMAdresse), 64'd0);
    LeseDaten = 1'b0;
    @(negedge Clock);
    Reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (DatenGeladen || DatenGespeichert || RAMLeseDaten) pulses++;
    end
    check("abort_noack", 64'(pulses), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
